exmem_stage: RTL and testbench

EXMEM_STAGE -- requirements
Module: exmem_stage

---
 rtl/exmem_stage.sv | 145 ++++++++++++++
 tb/tb_exmem_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage: captures an executed instruction (E), performs at most one
// data-memory access for it, and retires the result into the MEM/WB register (W).
module exmem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] ex_ALURes,
    input  logic [15:0] ex_rt,
    input  logic [15:0] ex_nextPC,
    input  logic        ex_err,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic        ex_regWrite,
    input  logic        ex_memToReg,
    input  logic        ex_halt,
    input  logic [2:0]  ex_writeReg,
    input  logic        flush,
    output logic        stall_out,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] exmem_ALURes,
    output logic        exmem_regWrite,
    output logic [2:0]  exmem_writeReg,
    output logic        memwb_valid,
    output logic        memwb_regWrite,
    output logic        memwb_halt,
    output logic        memwb_err,
    output logic [15:0] memwb_writeBack,
    output logic [2:0]  memwb_writeReg,
    output logic [15:0] memwb_nextPC,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

    state_t state, state_next;

    logic        e_valid, e_err, e_rd, e_wr, e_rw, e_m2r, e_halt;
    logic [15:0] e_alu, e_rt, e_npc;
    logic [2:0]  e_wreg;

    logic e_mem, e_bad, in_good, cap, complete, load_e;

    assign e_mem   = e_valid & (e_rd ^ e_wr);
    assign e_bad   = e_valid & ((e_rd & e_wr) | (e_mem & e_alu[0]));
    assign cap     = in_valid & ~flush;
    assign in_good = cap & (ex_memRead ^ ex_memWrite) & ~ex_ALURes[0];
    assign load_e  = ~stall_out;

    // Memory handshake: in ACCESS, mem_rd/mem_wr, mem_addr and mem_wdata are held
    // constant until the cycle mem_ack=1; that cycle completes the request and the
    // strobes drop after the edge. mem_ack outside ACCESS has no effect.
    always_comb begin
        stall_out  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        complete   = 1'b0;
        state_next = state;
        case (state)
            IDLE: complete = e_valid;
            ACCESS: begin
                mem_rd    = e_rd;
                mem_wr    = e_wr;
                mem_addr  = e_alu;
                mem_wdata = e_rt;
                stall_out = ~mem_ack;
                complete  = mem_ack;
            end
            HALTED: stall_out = 1'b1;
            default: state_next = IDLE;
        endcase
        if (state == IDLE || state == ACCESS) begin
            if (complete & e_halt)
                state_next = HALTED;
            else if (load_e)
                state_next = in_good ? ACCESS : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Invalid or flushed captures keep data but clear every control bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_err   <= 1'b0;
            e_rd    <= 1'b0;
            e_wr    <= 1'b0;
            e_rw    <= 1'b0;
            e_m2r   <= 1'b0;
            e_halt  <= 1'b0;
            e_alu   <= 16'h0000;
            e_rt    <= 16'h0000;
            e_npc   <= 16'h0000;
            e_wreg  <= 3'b000;
        end else if (load_e) begin
            e_valid <= cap;
            e_err   <= cap & ex_err;
            e_rd    <= cap & ex_memRead;
            e_wr    <= cap & ex_memWrite;
            e_rw    <= cap & ex_regWrite;
            e_m2r   <= cap & ex_memToReg;
            e_halt  <= cap & ex_halt;
            e_alu   <= ex_ALURes;
            e_rt    <= ex_rt;
            e_npc   <= ex_nextPC;
            e_wreg  <= ex_writeReg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !complete) begin
            memwb_valid     <= 1'b0;
            memwb_regWrite  <= 1'b0;
            memwb_halt      <= 1'b0;
            memwb_err       <= 1'b0;
            memwb_writeBack <= 16'h0000;
            memwb_writeReg  <= 3'b000;
            memwb_nextPC    <= 16'h0000;
        end else begin
            memwb_valid     <= 1'b1;
            memwb_regWrite  <= e_rw & ~e_bad;
            memwb_halt      <= e_halt;
            memwb_err       <= e_err | e_bad;
            memwb_writeBack <= e_m2r ? mem_rdata : e_alu;
            memwb_writeReg  <= e_wreg;
            memwb_nextPC    <= e_npc;
        end
    end

    assign exmem_ALURes   = e_valid ? e_alu : 16'h0000;
    assign exmem_regWrite = e_valid & e_rw;
    assign exmem_writeReg = e_valid ? e_wreg : 3'b000;
    assign fsm_state      = state;

endmodule

// File: tb/tb_exmem_stage.sv
// Bench for exmem_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against an instruction-level reference model.
module tb_exmem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, ex_err, ex_memRead, ex_memWrite, ex_regWrite, ex_memToReg, ex_halt;
    logic [15:0] ex_ALURes, ex_rt, ex_nextPC, mem_rdata;
    logic [2:0]  ex_writeReg;
    logic        flush, mem_ack;
    logic        stall_out, mem_rd, mem_wr, exmem_regWrite;
    logic [15:0] mem_addr, mem_wdata, exmem_ALURes;
    logic [2:0]  exmem_writeReg, memwb_writeReg;
    logic        memwb_valid, memwb_regWrite, memwb_halt, memwb_err;
    logic [15:0] memwb_writeBack, memwb_nextPC;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exmem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ex_ALURes(ex_ALURes), .ex_rt(ex_rt), .ex_nextPC(ex_nextPC), .ex_err(ex_err),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
        .ex_memToReg(ex_memToReg), .ex_halt(ex_halt), .ex_writeReg(ex_writeReg),
        .flush(flush), .stall_out(stall_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .exmem_ALURes(exmem_ALURes), .exmem_regWrite(exmem_regWrite),
        .exmem_writeReg(exmem_writeReg), .memwb_valid(memwb_valid),
        .memwb_regWrite(memwb_regWrite), .memwb_halt(memwb_halt), .memwb_err(memwb_err),
        .memwb_writeBack(memwb_writeBack), .memwb_writeReg(memwb_writeReg),
        .memwb_nextPC(memwb_nextPC), .fsm_state(fsm_state)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [15:0] alu, rt, npc;
        logic        err, rd, wr, rw, m2r, halt;
        logic [2:0]  wreg;
    } inst_t;

    typedef struct packed {
        logic        valid, rw, halt, err;
        logic [15:0] wb, npc;
        logic [2:0]  wreg;
    } wb_t;

    inst_t m_e;
    wb_t   m_w;
    logic  m_halted;

    function automatic logic well_formed_access(input inst_t i);
        return i.valid && (i.rd != i.wr) && !i.alu[0];
    endfunction

    function automatic logic malformed(input inst_t i);
        return i.valid && ((i.rd && i.wr) || ((i.rd != i.wr) && i.alu[0]));
    endfunction

    function automatic inst_t offered();
        inst_t i = '0;
        if (in_valid && !flush)
            i = '{1'b1, ex_ALURes, ex_rt, ex_nextPC, ex_err, ex_memRead, ex_memWrite,
                  ex_regWrite, ex_memToReg, ex_halt, ex_writeReg};
        return i;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic busy, hold, done;
        wb_t  r;
        if (rst) begin
            m_e      = '0;
            m_w      = '0;
            m_halted = 1'b0;
        end else begin
            busy = !m_halted && well_formed_access(m_e);
            hold = m_halted || (busy && !mem_ack);
            done = m_e.valid && !m_halted && (!busy || mem_ack);
            r = '0;
            if (done) begin
                r.valid = 1'b1;
                r.rw    = m_e.rw && !malformed(m_e);
                r.halt  = m_e.halt;
                r.err   = m_e.err || malformed(m_e);
                r.wb    = m_e.m2r ? mem_rdata : m_e.alu;
                r.npc   = m_e.npc;
                r.wreg  = m_e.wreg;
            end
            m_w = r;
            if (done && m_e.halt) m_halted = 1'b1;
            if (!hold) m_e = offered();
        end
    end

    always @(negedge clk) begin : compare
        logic busy;
        busy = !m_halted && well_formed_access(m_e);
        chk("stall_out", 16'(stall_out), 16'(m_halted || (busy && !mem_ack)));
        chk("mem_rd", 16'(mem_rd), 16'(busy && m_e.rd));
        chk("mem_wr", 16'(mem_wr), 16'(busy && m_e.wr));
        chk("mem_addr", mem_addr, busy ? m_e.alu : 16'h0000);
        chk("mem_wdata", mem_wdata, busy ? m_e.rt : 16'h0000);
        chk("exmem_ALURes", exmem_ALURes, m_e.valid ? m_e.alu : 16'h0000);
        chk("exmem_regWrite", 16'(exmem_regWrite), 16'(m_e.rw));
        chk("exmem_writeReg", 16'(exmem_writeReg), 16'(m_e.wreg));
        chk("memwb_valid", 16'(memwb_valid), 16'(m_w.valid));
        chk("memwb_regWrite", 16'(memwb_regWrite), 16'(m_w.rw));
        chk("memwb_halt", 16'(memwb_halt), 16'(m_w.halt));
        chk("memwb_err", 16'(memwb_err), 16'(m_w.err));
        chk("memwb_writeBack", memwb_writeBack, m_w.wb);
        chk("memwb_writeReg", 16'(memwb_writeReg), 16'(m_w.wreg));
        chk("memwb_nextPC", memwb_nextPC, m_w.npc);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; flush = 0; mem_ack = 0; mem_rdata = 16'h0000;
        ex_ALURes = 0; ex_rt = 0; ex_nextPC = 0; ex_err = 0;
        ex_memRead = 0; ex_memWrite = 0; ex_regWrite = 0; ex_memToReg = 0;
        ex_halt = 0; ex_writeReg = 0;
    endtask

    task automatic set_inst(input logic [15:0] alu, rt, npc,
                            input logic rd, wr, rw, m2r, halt, err,
                            input logic [2:0] wreg);
        set_idle();
        in_valid = 1; ex_ALURes = alu; ex_rt = rt; ex_nextPC = npc;
        ex_memRead = rd; ex_memWrite = wr; ex_regWrite = rw; ex_memToReg = m2r;
        ex_halt = halt; ex_err = err; ex_writeReg = wreg;
    endtask

    task automatic randomize_inputs();
        in_valid    = $urandom_range(0, 3) != 0;
        flush       = $urandom_range(0, 7) == 0;
        ex_ALURes   = 16'($urandom);
        if ($urandom_range(0, 3) != 0) ex_ALURes[0] = 1'b0;
        ex_rt       = 16'($urandom);
        ex_nextPC   = 16'($urandom);
        ex_err      = $urandom_range(0, 15) == 0;
        ex_memRead  = $urandom_range(0, 2) == 0;
        ex_memWrite = $urandom_range(0, 2) == 0;
        ex_regWrite = 1'($urandom_range(0, 1));
        ex_memToReg = 1'($urandom_range(0, 1));
        ex_halt     = $urandom_range(0, 63) == 0;
        ex_writeReg = 3'($urandom);
        mem_ack     = $urandom_range(0, 2) == 0;
        mem_rdata   = 16'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int halt_cycles;
        set_idle();
        cyc(); cyc();
        chk("reset_memwb_valid", 16'(memwb_valid), 16'h0);
        chk("reset_stall", 16'(stall_out), 16'h0);
        chk("reset_mem_rd", 16'(mem_rd), 16'h0);
        rst = 0;

        // ALU-only instruction, one-edge latency
        cyc();
        set_inst(16'h1234, 16'h0, 16'h0002, 0, 0, 1, 0, 0, 0, 3'd3);
        cyc(); set_idle(); #1;
        chk("alu_tap_ALURes", exmem_ALURes, 16'h1234);
        chk("alu_tap_writeReg", 16'(exmem_writeReg), 16'h3);
        chk("alu_stall", 16'(stall_out), 16'h0);
        cyc(); #1;
        chk("alu_wb", memwb_writeBack, 16'h1234);
        chk("alu_wreg", 16'(memwb_writeReg), 16'h3);
        chk("alu_valid", 16'(memwb_valid), 16'h1);
        chk("alu_stall2", 16'(stall_out), 16'h0);

        // load with two wait cycles
        set_inst(16'h0040, 16'h0, 16'h0010, 1, 0, 1, 1, 0, 0, 3'd5);
        cyc(); set_idle(); #1;
        chk("ld_rd_c1", 16'(mem_rd), 16'h1);
        chk("ld_stall_c1", 16'(stall_out), 16'h1);
        chk("ld_addr", mem_addr, 16'h0040);
        cyc(); #1;
        chk("ld_rd_c2", 16'(mem_rd), 16'h1);
        chk("ld_stall_c2", 16'(stall_out), 16'h1);
        cyc(); mem_ack = 1; mem_rdata = 16'hBEEF; #1;
        chk("ld_rd_c3", 16'(mem_rd), 16'h1);
        chk("ld_stall_c3", 16'(stall_out), 16'h0);
        cyc(); set_idle(); #1;
        chk("ld_wb", memwb_writeBack, 16'hBEEF);
        chk("ld_valid", 16'(memwb_valid), 16'h1);
        chk("ld_rd_after", 16'(mem_rd), 16'h0);

        // misaligned store
        set_inst(16'h0041, 16'h7777, 16'h0, 0, 1, 1, 0, 0, 0, 3'd2);
        cyc(); set_idle(); #1;
        chk("bad_st_wr", 16'(mem_wr), 16'h0);
        chk("bad_st_stall", 16'(stall_out), 16'h0);
        cyc(); #1;
        chk("bad_st_err", 16'(memwb_err), 16'h1);
        chk("bad_st_rw", 16'(memwb_regWrite), 16'h0);
        chk("bad_st_valid", 16'(memwb_valid), 16'h1);

        // flush during a store access
        set_inst(16'h0080, 16'h5555, 16'h0, 0, 1, 0, 0, 0, 0, 3'd0);
        cyc();
        set_inst(16'h9999, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0, 3'd4); flush = 1; #1;
        chk("fl_wr", 16'(mem_wr), 16'h1);
        chk("fl_wdata", mem_wdata, 16'h5555);
        chk("fl_stall", 16'(stall_out), 16'h1);
        cyc(); mem_ack = 1; #1;
        chk("fl_wr_ack", 16'(mem_wr), 16'h1);
        cyc(); set_idle(); #1;
        chk("fl_st_done", 16'(memwb_valid), 16'h1);
        chk("fl_bubble_rw", 16'(exmem_regWrite), 16'h0);
        chk("fl_bubble_alu", exmem_ALURes, 16'h0000);
        cyc(); #1;
        chk("fl_w_bubble", 16'(memwb_valid), 16'h0);

        // halt, then reset during an access
        set_inst(16'h0, 16'h0, 16'h00AA, 0, 0, 0, 0, 1, 0, 3'd0);
        cyc(); set_idle();
        cyc(); #1;
        chk("halt_w", 16'(memwb_halt), 16'h1);
        chk("halt_npc", memwb_nextPC, 16'h00AA);
        chk("halt_stall", 16'(stall_out), 16'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid = 1'(i); ex_ALURes = 16'h0100; ex_regWrite = 1; #1;
            chk("halted_stall", 16'(stall_out), 16'h1);
            chk("halted_bubble", 16'(memwb_valid), 16'h0);
        end
        cyc(); rst = 1; set_idle();
        cyc(); rst = 0;
        set_inst(16'h0010, 16'h0, 16'h0, 1, 0, 1, 1, 0, 0, 3'd1);
        cyc(); set_idle(); #1;
        chk("rst_pre_rd", 16'(mem_rd), 16'h1);
        rst = 1; #1;
        chk("rst_rd", 16'(mem_rd), 16'h0);
        chk("rst_stall", 16'(stall_out), 16'h0);
        chk("rst_tap", exmem_ALURes, 16'h0000);
        chk("rst_w", 16'(memwb_valid), 16'h0);
        cyc(); rst = 0;

        // random traffic
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (m_halted) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 299) == 0) begin
                set_idle();
                #2 rst = 1;
                cyc();
                rst = 0;
                halt_cycles = 0;
            end else begin
                randomize_inputs();
            end
        end
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
